bnn_mfcc_buf: RTL and testbench

BNN_MFCC_BUF -- requirements
Module: bnn_mfcc_buf

---
 rtl/bnn_mfcc_buf_if.sv | 20 ++
 rtl/bnn_mfcc_buf.sv | 125 ++++++++++++
 tb/tb_bnn_mfcc_buf.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bnn_mfcc_buf_if.sv
// Stream bundle between the APB write decoder, the MFCC frame buffer and the conv engine.
// The slave view belongs to the buffer; the master view belongs to whatever drives and consumes it.
interface bnn_mfcc_buf_if;
   logic        in_vld;
   logic [31:0] in_data;
   logic        feat_vld;
   logic        feat_rdy;
   logic [31:0] feat_data;
   logic        feat_last;

   modport slave (
      input  in_vld, in_data, feat_rdy,
      output feat_vld, feat_data, feat_last
   );

   modport master (
      output in_vld, in_data, feat_rdy,
      input  feat_vld, feat_data, feat_last
   );
endinterface

// File: rtl/bnn_mfcc_buf.sv
// Frame-granular circular buffer between the MFCC feature writer and the BNN conv engine.
// Only fully written frames are visible to the reader; FRAME_WORDS*DEPTH_FRAMES must be a power of two.
module bnn_mfcc_buf #(
   parameter int FRAME_WORDS  = 4,
   parameter int DEPTH_FRAMES = 8
) (
   input  logic            pclk,
   input  logic            presetn,
   input  logic            mfcc_wr_en,
   input  logic            clr,
   bnn_mfcc_buf_if.slave   bus,
   output logic [3:0]      frame_cnt,
   output logic            frame_done,
   output logic            full,
   output logic            ovf
);

   localparam int DEPTH = FRAME_WORDS * DEPTH_FRAMES;
   localparam int AW    = $clog2(DEPTH);
   localparam int WIW   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
   localparam logic [WIW-1:0] LAST_IDX = WIW'(FRAME_WORDS - 1);

   logic [31:0]    mem_r [DEPTH];
   logic [AW:0]    wptr_r, wptr_s;
   logic [AW:0]    rptr_r, rptr_s;
   logic [WIW-1:0] widx_r, widx_s;
   logic [WIW-1:0] ridx_r, ridx_s;
   logic [3:0]     frame_cnt_r, frame_cnt_s;
   logic           ovf_r, ovf_s;
   logic           frame_done_r;
   logic           full_s, feat_vld_s, feat_last_s;
   logic           wr_s, drop_s, commit_s, rd_s, consume_s;

   // Handshake decode and next-state computation for pointers, indices and flags.
   always_comb begin
      full_s      = (wptr_r[AW-1:0] == rptr_r[AW-1:0]) && (wptr_r[AW] != rptr_r[AW]);
      feat_vld_s  = (frame_cnt_r != 4'd0);
      feat_last_s = feat_vld_s && (ridx_r == LAST_IDX);
      wr_s        = mfcc_wr_en & bus.in_vld & ~full_s & ~clr;
      drop_s      = mfcc_wr_en & bus.in_vld &  full_s & ~clr;
      commit_s    = wr_s && (widx_r == LAST_IDX);
      rd_s        = feat_vld_s & bus.feat_rdy & ~clr;
      consume_s   = rd_s & feat_last_s;

      wptr_s      = wptr_r;
      rptr_s      = rptr_r;
      widx_s      = widx_r;
      ridx_s      = ridx_r;
      frame_cnt_s = frame_cnt_r;
      ovf_s       = ovf_r;

      if (clr) begin
         wptr_s      = '0;
         rptr_s      = '0;
         widx_s      = '0;
         ridx_s      = '0;
         frame_cnt_s = 4'd0;
         ovf_s       = 1'b0;
      end else begin
         if (wr_s) begin
            wptr_s = wptr_r + (AW+1)'(1);
            widx_s = commit_s ? '0 : widx_r + WIW'(1);
         end else if (drop_s) begin
            // Rewind over the partial frame so the committed frames stay intact.
            wptr_s = wptr_r - {{(AW+1-WIW){1'b0}}, widx_r};
            widx_s = '0;
            ovf_s  = 1'b1;
         end else begin
            wptr_s = wptr_r;
         end

         if (rd_s) begin
            rptr_s = rptr_r + (AW+1)'(1);
            ridx_s = feat_last_s ? '0 : ridx_r + WIW'(1);
         end else begin
            rptr_s = rptr_r;
         end

         if (commit_s && !consume_s) begin
            frame_cnt_s = frame_cnt_r + 4'd1;
         end else if (!commit_s && consume_s) begin
            frame_cnt_s = frame_cnt_r - 4'd1;
         end else begin
            frame_cnt_s = frame_cnt_r;
         end
      end
   end

   // Control state registers.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         wptr_r       <= '0;
         rptr_r       <= '0;
         widx_r       <= '0;
         ridx_r       <= '0;
         frame_cnt_r  <= 4'd0;
         ovf_r        <= 1'b0;
         frame_done_r <= 1'b0;
      end else begin
         wptr_r       <= wptr_s;
         rptr_r       <= rptr_s;
         widx_r       <= widx_s;
         ridx_r       <= ridx_s;
         frame_cnt_r  <= frame_cnt_s;
         ovf_r        <= ovf_s;
         frame_done_r <= commit_s;
      end
   end

   // Word storage, deliberately left out of reset and flush.
   always_ff @(posedge pclk) begin
      if (wr_s) begin
         mem_r[wptr_r[AW-1:0]] <= bus.in_data;
      end
   end

   assign bus.feat_vld  = feat_vld_s;
   assign bus.feat_last = feat_last_s;
   assign bus.feat_data = mem_r[rptr_r[AW-1:0]];
   assign frame_cnt     = frame_cnt_r;
   assign frame_done    = frame_done_r;
   assign full          = full_s;
   assign ovf           = ovf_r;

endmodule

// File: tb/tb_bnn_mfcc_buf.sv
// Directed self-checking bench for bnn_mfcc_buf at default parameters (4 words/frame, 8 frames).
module tb_bnn_mfcc_buf;
   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        mfcc_wr_en = 1'b0;
   logic        clr = 1'b0;
   logic [3:0]  frame_cnt;
   logic        frame_done, full, ovf;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] q[$];
   logic [31:0] exp_word;
   int          w, r, cyc, exp_cnt;
   logic        exp_vld;

   bnn_mfcc_buf_if bus();

   bnn_mfcc_buf #(.FRAME_WORDS(4), .DEPTH_FRAMES(8)) dut (
      .pclk(pclk), .presetn(presetn), .mfcc_wr_en(mfcc_wr_en), .clr(clr),
      .bus(bus), .frame_cnt(frame_cnt), .frame_done(frame_done), .full(full), .ovf(ovf)
   );

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wr(input logic [31:0] d);
      bus.in_vld  = 1'b1;
      bus.in_data = d;
      tick();
      bus.in_vld  = 1'b0;
   endtask

   task automatic rd_expect(input string tag, input logic [31:0] d, input logic last);
      check({tag, "_vld"}, {31'd0, bus.feat_vld}, 32'd1);
      check({tag, "_data"}, bus.feat_data, d);
      check({tag, "_last"}, {31'd0, bus.feat_last}, {31'd0, last});
      bus.feat_rdy = 1'b1;
      tick();
      bus.feat_rdy = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cnt"},  {28'd0, frame_cnt}, 32'd0);
      check({tag, "_vld"},  {31'd0, bus.feat_vld}, 32'd0);
      check({tag, "_last"}, {31'd0, bus.feat_last}, 32'd0);
      check({tag, "_done"}, {31'd0, frame_done}, 32'd0);
      check({tag, "_full"}, {31'd0, full}, 32'd0);
      check({tag, "_ovf"},  {31'd0, ovf}, 32'd0);
   endtask

   initial begin
      bus.in_vld   = 1'b0;
      bus.in_data  = 32'd0;
      bus.feat_rdy = 1'b0;
      #2;
      check_idle("rst");
      tick();
      tick();
      presetn = 1'b1;
      tick();

      // Single frame, reader always ready
      mfcc_wr_en   = 1'b1;
      bus.feat_rdy = 1'b1;
      for (int i = 0; i < 3; i++) wr(32'h0302_0100 + 32'h0404_0404 * 32'(i));
      check("t1_vld_early", {31'd0, bus.feat_vld}, 32'd0);
      check("t1_cnt_early", {28'd0, frame_cnt}, 32'd0);
      wr(32'h0F0E_0D0C);
      check("t1_done", {31'd0, frame_done}, 32'd1);
      check("t1_cnt1", {28'd0, frame_cnt}, 32'd1);
      for (int i = 0; i < 4; i++) rd_expect("t1_rd", 32'h0302_0100 + 32'h0404_0404 * 32'(i), (i == 3));
      check("t1_done_pulse", {31'd0, frame_done}, 32'd0);
      check("t1_cnt0", {28'd0, frame_cnt}, 32'd0);

      // Fill to capacity, then one word too many
      bus.feat_rdy = 1'b0;
      for (int k = 0; k < 32; k++) wr(32'hA000_0000 + 32'(k));
      check("t2_full", {31'd0, full}, 32'd1);
      check("t2_cnt8", {28'd0, frame_cnt}, 32'd8);
      check("t2_ovf0", {31'd0, ovf}, 32'd0);
      wr(32'hDEAD_BEEF);
      check("t2_ovf1", {31'd0, ovf}, 32'd1);
      check("t2_cnt_keep", {28'd0, frame_cnt}, 32'd8);
      for (int k = 0; k < 32; k++) rd_expect("t2_rd", 32'hA000_0000 + 32'(k), (k % 4 == 3));
      check("t2_empty_cnt", {28'd0, frame_cnt}, 32'd0);
      check("t2_empty_full", {31'd0, full}, 32'd0);

      // Gated strobes, then flush colliding with write and read
      mfcc_wr_en = 1'b0;
      for (int k = 0; k < 3; k++) wr(32'h1111_0000 + 32'(k));
      check("t3_gate_cnt", {28'd0, frame_cnt}, 32'd0);
      check("t3_gate_vld", {31'd0, bus.feat_vld}, 32'd0);
      check("t3_gate_ovf", {31'd0, ovf}, 32'd1);
      mfcc_wr_en = 1'b1;
      for (int k = 0; k < 4; k++) wr(32'hB000_0000 + 32'(k));
      check("t3_cnt1", {28'd0, frame_cnt}, 32'd1);
      clr = 1'b1; bus.in_vld = 1'b1; bus.in_data = 32'h2222_2222; bus.feat_rdy = 1'b1;
      tick();
      clr = 1'b0; bus.in_vld = 1'b0; bus.feat_rdy = 1'b0;
      check_idle("t3_clr");

      // Partial frame discarded on overflow; committed frames survive
      for (int k = 0; k < 32; k++) wr(32'hC000_0000 + 32'(k));
      rd_expect("t4_c0", 32'hC000_0000, 1'b0);
      rd_expect("t4_c1", 32'hC000_0001, 1'b0);
      wr(32'hD000_0000);
      wr(32'hD000_0001);
      check("t4_full", {31'd0, full}, 32'd1);
      wr(32'hD000_0002);
      check("t4_ovf", {31'd0, ovf}, 32'd1);
      check("t4_rewound", {31'd0, full}, 32'd0);
      check("t4_cnt8", {28'd0, frame_cnt}, 32'd8);
      rd_expect("t4_c2", 32'hC000_0002, 1'b0);
      rd_expect("t4_c3", 32'hC000_0003, 1'b1);
      check("t4_cnt7", {28'd0, frame_cnt}, 32'd7);
      for (int k = 0; k < 4; k++) wr(32'hE000_0000 + 32'(k));
      check("t4_cnt_refill", {28'd0, frame_cnt}, 32'd8);
      check("t4_full2", {31'd0, full}, 32'd1);
      for (int k = 4; k < 32; k++) rd_expect("t4_rd", 32'hC000_0000 + 32'(k), (k % 4 == 3));
      for (int k = 0; k < 4; k++) rd_expect("t4_new", 32'hE000_0000 + 32'(k), (k == 3));

      // Concurrent streaming across 20 frames with pointer wrap
      clr = 1'b1;
      tick();
      clr = 1'b0;
      w = 0; r = 0; cyc = 0;
      while (r < 80 && cyc < 1000) begin
         exp_cnt = w / 4 - r / 4;
         exp_vld = (exp_cnt != 0);
         check("t5_vld", {31'd0, bus.feat_vld}, {31'd0, exp_vld});
         bus.in_vld   = (w < 80) && (cyc % 2 == 0);
         bus.in_data  = 32'h5000_0000 + 32'(w);
         bus.feat_rdy = (cyc % 3 != 2);
         if (bus.feat_rdy && exp_vld) begin
            exp_word = q.pop_front();
            check("t5_data", bus.feat_data, exp_word);
            check("t5_last", {31'd0, bus.feat_last}, {31'd0, (r % 4 == 3)});
            r++;
         end
         if (bus.in_vld) begin
            q.push_back(bus.in_data);
            w++;
         end
         tick();
         cyc++;
         check("t5_cnt", {28'd0, frame_cnt}, 32'(w / 4 - r / 4));
      end
      bus.in_vld = 1'b0; bus.feat_rdy = 1'b0;
      check("t5_all_read", 32'(r), 32'd80);
      check("t5_ovf", {31'd0, ovf}, 32'd0);

      // Enable dropping mid-frame keeps the partial frame
      wr(32'h6000_0000);
      wr(32'h6000_0001);
      mfcc_wr_en = 1'b0;
      wr(32'h7777_7777);
      mfcc_wr_en = 1'b1;
      wr(32'h6000_0002);
      check("t6_cnt0", {28'd0, frame_cnt}, 32'd0);
      wr(32'h6000_0003);
      check("t6_done", {31'd0, frame_done}, 32'd1);
      for (int k = 0; k < 4; k++) rd_expect("t6_rd", 32'h6000_0000 + 32'(k), (k == 3));

      // Asynchronous reset in the middle of reading frame 2
      for (int k = 0; k < 8; k++) wr(32'h8000_0000 + 32'(k));
      for (int k = 0; k < 5; k++) rd_expect("t7_rd", 32'h8000_0000 + 32'(k), (k == 3));
      #2 presetn = 1'b0;
      #1 check_idle("t7_arst");
      #1 presetn = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) wr(32'h9000_0000 + 32'(k));
      check("t7_done", {31'd0, frame_done}, 32'd1);
      check("t7_cnt1", {28'd0, frame_cnt}, 32'd1);
      for (int k = 0; k < 4; k++) rd_expect("t7_new", 32'h9000_0000 + 32'(k), (k == 3));
      check("t7_cnt0", {28'd0, frame_cnt}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
